// File: rtl/ubus_slave_mem.sv
// ubus_slave_mem: byte-addressed UBUS slave memory; ERR state and bip/read-write checks are built only with UBUS_SLV_PROTO_CHECK_EN.
// Latency: first data beat NUM_WAIT+1 cycles after the address phase, then one byte per beat.
// Backpressure: NUM_WAIT wait_state cycles precede every beat; address phases outside IDLE are ignored.
module ubus_slave_mem #(
    parameter logic [15:0] ADDR_LO   = 16'h0000,
    parameter logic [15:0] ADDR_HI   = 16'h00FF,
    parameter int          MEM_DEPTH = 256,
    parameter int          NUM_WAIT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [1:0]  size,
    input  logic        read,
    input  logic        write,
    input  logic        bip,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        wait_state,
    output logic        error
);
    localparam int          AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int          PW        = AW + 1;
    localparam logic [15:0] SPAN      = ADDR_HI - ADDR_LO;
    localparam logic [2:0]  WAIT_LAST = (NUM_WAIT > 0) ? 3'(NUM_WAIT - 1) : 3'd0;
    localparam logic [PW-1:0] DEPTH_W = PW'(MEM_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA, S_ERR} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] base_q;
    logic [1:0]    size_q;
    logic          dir_wr_q;
    logic [2:0]    beat_q;
    logic [2:0]    wait_q;
    logic [7:0]    mem [MEM_DEPTH];

    logic [16:0]   off;
    logic          sel;
    logic          rw_both;
    logic          accept;
    logic [2:0]    last_idx;
    logic          last_beat;
    logic [PW-1:0] ptr_sum;
    logic [AW-1:0] ptr;
    logic          proto_err;
    logic          mem_we;

    // Borrow bit of the offset doubles as the addr < ADDR_LO test.
    always_comb begin
        off = {1'b0, addr} - {1'b0, ADDR_LO};
        sel = (read | write) && !off[16] && (off[15:0] <= SPAN);

        case (size_q)
            2'd0:    last_idx = 3'd0;
            2'd1:    last_idx = 3'd1;
            2'd2:    last_idx = 3'd3;
            default: last_idx = 3'd7;
        endcase
        last_beat = (beat_q == last_idx);

        ptr_sum = {1'b0, base_q} + PW'(beat_q);
        ptr     = (ptr_sum >= DEPTH_W) ? AW'(ptr_sum - DEPTH_W) : ptr_sum[AW-1:0];
    end

`ifdef UBUS_SLV_PROTO_CHECK_EN
    assign rw_both   = read & write;
    assign proto_err = (state == S_DATA) && (bip == last_beat);
`else
    logic unused_bip;
    assign unused_bip = bip;
    assign rw_both    = 1'b0;
    assign proto_err  = 1'b0;
`endif

    assign accept = (state == S_IDLE) && sel && !rw_both;
    assign mem_we = (state == S_DATA) && dir_wr_q && !proto_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (sel) begin
                    if (rw_both)           state_nxt = S_ERR;
                    else if (NUM_WAIT > 0) state_nxt = S_WAIT;
                    else                   state_nxt = S_DATA;
                end
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (proto_err)         state_nxt = S_ERR;
                else if (last_beat)    state_nxt = S_IDLE;
                else if (NUM_WAIT > 0) state_nxt = S_WAIT;
                else                   state_nxt = S_DATA;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        wait_state = (state == S_WAIT);
        data_oe    = (state == S_DATA) && !dir_wr_q;
        data_out   = data_oe ? mem[ptr] : 8'h00;
`ifdef UBUS_SLV_PROTO_CHECK_EN
        error      = (state == S_ERR);
`else
        error      = 1'b0;
`endif
    end

    // A read/write collision without checking falls through as a write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            base_q   <= '0;
            size_q   <= '0;
            dir_wr_q <= 1'b0;
            beat_q   <= '0;
            wait_q   <= '0;
        end else begin
            wait_q <= (state == S_WAIT) ? wait_q + 3'd1 : 3'd0;
            if (accept) begin
                base_q   <= AW'(off[15:0] % 16'(MEM_DEPTH));
                size_q   <= size;
                dir_wr_q <= write;
                beat_q   <= '0;
            end else if ((state == S_DATA) && !proto_err && !last_beat) begin
                beat_q <= beat_q + 3'd1;
            end
        end
    end

    // Storage is never cleared; reset only blocks the in-flight write.
    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            mem[ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_ubus_slave_mem.sv
// Bench for ubus_slave_mem: instance d has NUM_WAIT=d; directed table, corner sequences, then random transfers against a byte-array model.
module tb_ubus_slave_mem;
    logic             clk = 1'b0;
    logic             reset;
    logic [1:0][15:0] addr;
    logic [1:0][1:0]  size;
    logic [1:0]       read;
    logic [1:0]       write;
    logic [1:0]       bip;
    logic [1:0][7:0]  data_in;
    logic [1:0][7:0]  data_out;
    logic [1:0]       data_oe;
    logic [1:0]       wait_state;
    logic [1:0]       error;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] mm [2][256];

    typedef struct {
        int          d;
        logic [15:0] a;
        logic [1:0]  sz;
        bit          wr;
        logic [63:0] dat;
    } vec_t;

    vec_t tbl [10];

    always #5 clk = ~clk;

    ubus_slave_mem #(.NUM_WAIT(0)) u_w0 (
        .clk(clk), .reset(reset), .addr(addr[0]), .size(size[0]), .read(read[0]),
        .write(write[0]), .bip(bip[0]), .data_in(data_in[0]), .data_out(data_out[0]),
        .data_oe(data_oe[0]), .wait_state(wait_state[0]), .error(error[0])
    );

    ubus_slave_mem #(.NUM_WAIT(1)) u_w1 (
        .clk(clk), .reset(reset), .addr(addr[1]), .size(size[1]), .read(read[1]),
        .write(write[1]), .bip(bip[1]), .data_in(data_in[1]), .data_out(data_out[1]),
        .data_oe(data_oe[1]), .wait_state(wait_state[1]), .error(error[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Packs {wait_state, data_oe, error, data_out}; data_out only compared when cmp_d.
    task automatic chk_out(input int d, input string tag, input bit ws, input bit oe,
                           input bit er, input bit cmp_d, input logic [7:0] dout);
        logic [10:0] act;
        logic [10:0] exp;
        act = {wait_state[d], data_oe[d], error[d], cmp_d ? data_out[d] : 8'h00};
        exp = {ws, oe, er, cmp_d ? dout : 8'h00};
        chk($sformatf("%s d%0d", tag, d), 32'(act), 32'(exp));
    endtask

    task automatic idle_in(input int d);
        addr[d] = 16'h0; size[d] = 2'd0; read[d] = 1'b0; write[d] = 1'b0;
        bip[d] = 1'b0; data_in[d] = 8'h00;
    endtask

    // Called at a negedge; returns at a negedge with the DUT back in IDLE.
    task automatic do_xfer(input int d, input logic [15:0] a, input logic [1:0] sz, input bit wr,
                           input bit both, input int bad_bip, input logic [63:0] wd,
                           input bit use_exp, input logic [63:0] ed);
        int nb;
        int idx;
        bit sel;
        logic [7:0] e;
        nb  = 1 << sz;
        sel = (a <= 16'h00FF);
        addr[d] = a; size[d] = sz; read[d] = !wr || both; write[d] = wr; bip[d] = 1'b0;
        @(negedge clk);
        idle_in(d);
        if (!sel) begin
            for (int c = 0; c < 4; c++) begin
                chk_out(d, "out_of_range", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
                @(negedge clk);
            end
            return;
        end
`ifdef UBUS_SLV_PROTO_CHECK_EN
        if (both) begin
            chk_out(d, "rw_err_pulse", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            @(negedge clk);
            chk_out(d, "rw_err_end", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            return;
        end
`endif
        for (int k = 0; k < nb; k++) begin
            bit last;
            last = (k == nb - 1);
            for (int w = 0; w < d; w++) begin
                chk_out(d, "wait", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
                @(negedge clk);
            end
            idx = (int'(a) + k) % 256;
            e   = use_exp ? ed[8*k +: 8] : mm[d][idx];
            chk_out(d, wr ? "wbeat" : "rbeat", 1'b0, !wr, 1'b0, !wr, e);
            bip[d] = (k == bad_bip) ? last : !last;
            if (wr) data_in[d] = wd[8*k +: 8];
            @(negedge clk);
            bip[d] = 1'b0;
            data_in[d] = 8'h00;
`ifdef UBUS_SLV_PROTO_CHECK_EN
            if (k == bad_bip) begin
                chk_out(d, "bip_err_pulse", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
                @(negedge clk);
                chk_out(d, "bip_err_end", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
                return;
            end
`endif
            if (wr) mm[d][idx] = wd[8*k +: 8];
        end
        chk_out(d, "post_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        tbl[0] = '{1, 16'h0010, 2'd2, 1'b1, 64'hD4C3B2A1};
        tbl[1] = '{1, 16'h0010, 2'd2, 1'b0, 64'hD4C3B2A1};
        tbl[2] = '{0, 16'h00FC, 2'd3, 1'b1, 64'h8877665544332211};
        tbl[3] = '{0, 16'h00FC, 2'd3, 1'b0, 64'h8877665544332211};
        tbl[4] = '{0, 16'h0000, 2'd2, 1'b0, 64'h88776655};
        tbl[5] = '{0, 16'h0000, 2'd0, 1'b1, 64'h5A};
        tbl[6] = '{0, 16'h0100, 2'd0, 1'b1, 64'hC3};
        tbl[7] = '{0, 16'h0000, 2'd0, 1'b0, 64'h5A};
        tbl[8] = '{1, 16'h01FF, 2'd1, 1'b1, 64'h9999};
        tbl[9] = '{1, 16'h0011, 2'd1, 1'b0, 64'hC3B2};

        reset = 1'b0;
        idle_in(0);
        idle_in(1);
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) chk_out(d, "reset_state", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        reset = 1'b1;
        @(negedge clk);

        // Fill both memories so every later read has a defined expectation.
        for (int d = 0; d < 2; d++)
            for (int b = 0; b < 32; b++)
                do_xfer(d, 16'(b * 8), 2'd3, 1'b1, 1'b0, -1, {$urandom, $urandom}, 1'b0, 64'h0);

        for (int i = 0; i < 10; i++)
            do_xfer(tbl[i].d, tbl[i].a, tbl[i].sz, tbl[i].wr, 1'b0, -1, tbl[i].dat, !tbl[i].wr, tbl[i].dat);

        // Reset during beat 2 of a 4-beat write: only the first byte lands.
        addr[1] = 16'h0040; size[1] = 2'd2; write[1] = 1'b1;
        @(negedge clk);
        idle_in(1);
        chk_out(1, "rst_wait0", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk_out(1, "rst_beat0", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        data_in[1] = 8'h11; bip[1] = 1'b1;
        @(negedge clk);
        mm[1][8'h40] = 8'h11;
        data_in[1] = 8'h00; bip[1] = 1'b0;
        chk_out(1, "rst_wait1", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk_out(1, "rst_beat1", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        data_in[1] = 8'h22; bip[1] = 1'b1; reset = 1'b0;
        @(negedge clk);
        chk_out(1, "rst_abort", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        reset = 1'b1;
        idle_in(1);
        @(negedge clk);
        chk_out(1, "rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        do_xfer(1, 16'h0040, 2'd2, 1'b0, 1'b0, -1, 64'h0, 1'b0, 64'h0);

        // bip low on the first beat of a 2-beat write, then read back.
        do_xfer(1, 16'h0030, 2'd1, 1'b1, 1'b0, 0, 64'h9E9F, 1'b0, 64'h0);
        do_xfer(1, 16'h0030, 2'd1, 1'b0, 1'b0, -1, 64'h0, 1'b0, 64'h0);

        // read and write together in one address phase.
        do_xfer(1, 16'h0020, 2'd0, 1'b1, 1'b1, -1, 64'h3C, 1'b0, 64'h0);
        do_xfer(1, 16'h0020, 2'd0, 1'b0, 1'b0, -1, 64'h0, 1'b0, 64'h0);

        for (int i = 0; i < 80; i++) begin
            int d;
            d = int'($urandom_range(1, 0));
            do_xfer(d, 16'($urandom_range(16'h013F, 0)), 2'($urandom_range(3, 0)),
                    bit'($urandom_range(1, 0)), 1'b0, -1, {$urandom, $urandom}, 1'b0, 64'h0);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
